// File: rtl/blake_msg_fifo.sv
`timescale 1ns/1ps
// Purpose: DEPTH-slot message-block queue feeding an active message register for the Blake-512 rounds.
// Latency: a pushed block can be popped the next cycle; a popped block shows on msg_out one cycle after init_round.
// Backpressure: din_ready drops when all DEPTH slots are full; a same-cycle pop does not reopen it.
//
// Ports:
//   clk, rstb (async, active-high), clr (sync flush of queue, active register and error flags)
//   din/din_valid/din_ready : push handshake; swap_en byte-reverses each 64-bit lane on push
//   init_round              : pop head into msg_out (ignored while round_ing or queue empty)
//   round_ing               : rounds are consuming msg_out; the active register is locked
//   msg_out/msg_valid       : active message register and its valid flag
//   count                   : queued blocks, not counting the active register
//   err_underflow, err_busy : sticky flags for rejected init_round pulses
module blake_msg_fifo #(
    parameter int MSG_W = 640,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             clr,
    input  logic [MSG_W-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             swap_en,
    input  logic             init_round,
    input  logic             round_ing,
    output logic [MSG_W-1:0] msg_out,
    output logic             msg_valid,
    output logic [CNT_W-1:0] count,
    output logic             err_underflow,
    output logic             err_busy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LANES = MSG_W / 64;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [MSG_W-1:0] slot [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [MSG_W-1:0] din_sw;
    logic             do_push;
    logic             do_pop;
    logic             q_empty;

    // Ready depends on registered count only, so there is no path from init_round to din_ready.
    assign din_ready = (count != FULL);
    assign q_empty   = (count == '0);

    // clr discards any same-cycle transfer so the flush lands on a clean state.
    assign do_push = din_valid && din_ready && !clr;
    assign do_pop  = init_round && !round_ing && !q_empty && !clr;

    // Lane-wise endianness swap; lane order is preserved, bytes within each lane reversed.
    always_comb begin
        din_sw = din;
        if (swap_en) begin
            for (int l = 0; l < LANES; l++) begin
                for (int b = 0; b < 8; b++) begin
                    din_sw[64*l + 8*b +: 8] = din[64*l + 8*(7-b) +: 8];
                end
            end
        end
    end

    // Slot storage needs no reset: a slot is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            slot[wr_ptr] <= din_sw;
        end
    end

    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            msg_out       <= '0;
            msg_valid     <= 1'b0;
            err_underflow <= 1'b0;
            err_busy      <= 1'b0;
        end else if (clr) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            msg_out       <= '0;
            msg_valid     <= 1'b0;
            err_underflow <= 1'b0;
            err_busy      <= 1'b0;
        end else begin
            // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            // The pop reads the pre-edge head, so with one entry queued a concurrent
            // push can never be the block that lands in msg_out.
            if (do_pop) begin
                rd_ptr    <= rd_ptr + PTR_W'(1);
                msg_out   <= slot[rd_ptr];
                msg_valid <= 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (init_round && q_empty) begin
                err_underflow <= 1'b1;
            end
            if (init_round && round_ing) begin
                err_busy <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_blake_msg_fifo.sv
`timescale 1ns/1ps
module tb_blake_msg_fifo;

    localparam int MSG_W = 640;
    localparam int DEPTH = 2;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rstb = 1'b1;
    logic             clr = 1'b0;
    logic [MSG_W-1:0] din = '0;
    logic             din_valid = 1'b0;
    logic             din_ready;
    logic             swap_en = 1'b0;
    logic             init_round = 1'b0;
    logic             round_ing = 1'b0;
    logic [MSG_W-1:0] msg_out;
    logic             msg_valid;
    logic [CNT_W-1:0] count;
    logic             err_underflow;
    logic             err_busy;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    blake_msg_fifo #(.MSG_W(MSG_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rstb          (rstb),
        .clr           (clr),
        .din           (din),
        .din_valid     (din_valid),
        .din_ready     (din_ready),
        .swap_en       (swap_en),
        .init_round    (init_round),
        .round_ing     (round_ing),
        .msg_out       (msg_out),
        .msg_valid     (msg_valid),
        .count         (count),
        .err_underflow (err_underflow),
        .err_busy      (err_busy)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [MSG_W-1:0] q [$];
    logic [MSG_W-1:0] m_out  = '0;
    bit               m_vld  = 1'b0;
    bit               m_uf   = 1'b0;
    bit               m_busy = 1'b0;
    int               mn;

    function automatic logic [MSG_W-1:0] bswap(input logic [MSG_W-1:0] d);
        logic [MSG_W-1:0] r;
        logic [63:0]      lane;
        r = '0;
        for (int i = 0; i < MSG_W / 64; i++) begin
            lane = d[64*i +: 64];
            r[64*i +: 64] = {<<8{lane}};
        end
        return r;
    endfunction

    always @(posedge clk or posedge rstb) begin
        if (rstb || clr) begin
            q.delete();
            m_out  = '0;
            m_vld  = 1'b0;
            m_uf   = 1'b0;
            m_busy = 1'b0;
        end else begin
            mn = q.size();
            if (init_round && mn == 0) m_uf = 1'b1;
            if (init_round && round_ing) m_busy = 1'b1;
            if (init_round && !round_ing && mn != 0) begin
                m_out = q.pop_front();
                m_vld = 1'b1;
            end
            if (din_valid && mn != DEPTH) q.push_back(swap_en ? bswap(din) : din);
        end
    end

    task automatic chk(input string nm, input logic [MSG_W-1:0] act, input logic [MSG_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // One compare process, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_count",     MSG_W'(count),         MSG_W'(q.size()));
            chk("m_din_ready", MSG_W'(din_ready),     MSG_W'(q.size() != DEPTH));
            chk("m_msg_out",   msg_out,               m_out);
            chk("m_msg_valid", MSG_W'(msg_valid),     MSG_W'(m_vld));
            chk("m_err_uf",    MSG_W'(err_underflow), MSG_W'(m_uf));
            chk("m_err_busy",  MSG_W'(err_busy),      MSG_W'(m_busy));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        din_valid  = 1'b0;
        init_round = 1'b0;
        clr        = 1'b0;
        round_ing  = 1'b0;
        swap_en    = 1'b0;
    endtask

    task automatic push(input logic [MSG_W-1:0] d, input logic sw);
        din = d; swap_en = sw; din_valid = 1'b1; init_round = 1'b0;
        tick();
        din_valid = 1'b0; swap_en = 1'b0;
    endtask

    task automatic pop();
        init_round = 1'b1;
        tick();
        init_round = 1'b0;
    endtask

    logic [MSG_W-1:0] A, B, C, D, E, F, SW_IN, SW_EXP;

    initial begin
        A      = {10{64'h0123456789ABCDEF}};
        B      = {10{64'hB0B1B2B3B4B5B6B7}};
        C      = {10{64'hC0C1C2C3C4C5C6C7}};
        D      = {10{64'hD0D1D2D3D4D5D6D7}};
        E      = {10{64'hE0E1E2E3E4E5E6E7}};
        F      = {10{64'hF0F1F2F3F4F5F6F7}};
        SW_IN  = {10{64'h0011223344556677}};
        SW_EXP = {10{64'h7766554433221100}};

        // Reset state
        idle();
        rstb = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_msg_out",   msg_out, '0);
        chk("rst_msg_valid", MSG_W'(msg_valid), '0);
        chk("rst_count",     MSG_W'(count), '0);
        chk("rst_flags",     MSG_W'({err_underflow, err_busy}), '0);
        rstb = 1'b0;
        #1;
        chk("rst_ready", MSG_W'(din_ready), MSG_W'(1));
        cmp_en = 1'b1;
        tick();

        // 1: plain push then pop
        push(A, 1'b0);
        pop();
        chk("t1_msg_out", msg_out, A);
        chk("t1_valid",   MSG_W'(msg_valid), MSG_W'(1));
        chk("t1_count",   MSG_W'(count), '0);

        // 2: lane byte swap
        push(SW_IN, 1'b1);
        pop();
        chk("t2_swap", msg_out, SW_EXP);

        // 3: full queue backpressure and pointer wrap
        push(A, 1'b0);
        push(B, 1'b0);
        din = C; din_valid = 1'b1;
        #0;
        chk("t3_ready_full", MSG_W'(din_ready), '0);
        tick();
        din_valid = 1'b0;
        chk("t3_count_full", MSG_W'(count), MSG_W'(2));
        pop();
        chk("t3_pop_a", msg_out, A);
        push(C, 1'b0);
        pop();
        chk("t3_pop_b", msg_out, B);
        pop();
        chk("t3_pop_c", msg_out, C);
        chk("t3_count0", MSG_W'(count), '0);

        // 4: simultaneous push and pop with one entry
        push(A, 1'b0);
        din = B; din_valid = 1'b1; init_round = 1'b1;
        tick();
        idle();
        chk("t4_older", msg_out, A);
        chk("t4_count", MSG_W'(count), MSG_W'(1));
        pop();
        chk("t4_next", msg_out, B);

        // 5: rejected init_round
        pop();
        chk("t5_uf",      MSG_W'(err_underflow), MSG_W'(1));
        chk("t5_uf_hold", msg_out, B);
        push(C, 1'b0);
        round_ing = 1'b1; init_round = 1'b1;
        tick();
        idle();
        chk("t5_busy",      MSG_W'(err_busy), MSG_W'(1));
        chk("t5_busy_cnt",  MSG_W'(count), MSG_W'(1));
        chk("t5_busy_hold", msg_out, B);

        // 6: async reset mid-stream, then synchronous clr
        push(D, 1'b0);
        chk("t6_pre_cnt", MSG_W'(count), MSG_W'(2));
        rstb = 1'b1;
        #1;
        chk("t6_rst_cnt",   MSG_W'(count), '0);
        chk("t6_rst_valid", MSG_W'(msg_valid), '0);
        chk("t6_rst_out",   msg_out, '0);
        chk("t6_rst_flags", MSG_W'({err_underflow, err_busy}), '0);
        tick();
        rstb = 1'b0;
        tick();
        push(E, 1'b0);
        push(F, 1'b0);
        pop();
        chk("t6_pop_e", msg_out, E);
        round_ing = 1'b1; init_round = 1'b1;
        tick();
        idle();
        chk("t6_busy", MSG_W'(err_busy), MSG_W'(1));
        clr = 1'b1; din = A; din_valid = 1'b1; init_round = 1'b1;
        tick();
        idle();
        chk("t6_clr_cnt",   MSG_W'(count), '0);
        chk("t6_clr_valid", MSG_W'(msg_valid), '0);
        chk("t6_clr_out",   msg_out, '0);
        chk("t6_clr_flags", MSG_W'({err_underflow, err_busy}), '0);

        // Randomized traffic checked by the model every cycle
        for (int n = 0; n < 4000; n++) begin
            for (int i = 0; i < MSG_W / 32; i++) din[32*i +: 32] = $urandom;
            din_valid  = ($urandom_range(0, 3) != 0);
            swap_en    = $urandom_range(0, 1) != 0;
            init_round = ($urandom_range(0, 2) == 0);
            round_ing  = ($urandom_range(0, 4) == 0);
            clr        = ($urandom_range(0, 99) == 0);
            rstb       = ($urandom_range(0, 249) == 0);
            tick();
        end
        idle();
        rstb = 1'b0;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/blake_msg_fifo.md
Name: blake_msg_fifo

Overview:
- Parametrised successor to the single-register message buffer in the Blake-512 core.
- Queues up to DEPTH message blocks from the input side through a valid/ready handshake.
- Optionally byte-swaps each 64-bit lane at push time.
- Transfers the head block into an active message register on init_round, so the next blocks can be loaded while the round engine consumes the current one.

Parameters:
- MSG_W, 640, message block width in bits; must be a multiple of 64.
- DEPTH, 2, number of queued slots; must be a power of two, at least 2.
- CNT_W, $clog2(DEPTH+1), occupancy counter width.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rstb  input  1  asynchronous reset, active-high; port name kept from the codebase, polarity is high.
- clr  input  1  synchronous flush of queue, active register and error flags.
- din  input  MSG_W  raw message block.
- din_valid  input  1  din holds a block to push.
- din_ready  output  1  queue can accept a push this cycle.
- swap_en  input  1  sampled with the push; byte-reverse each 64-bit lane of din.
- init_round  input  1  single-cycle pulse; pop the head into the active register.
- round_ing  input  1  high while the rounds use msg_out; the active register is locked.
- msg_out  output  MSG_W  active message register.
- msg_valid  output  1  active register holds a popped block.
- count  output  CNT_W  number of queued blocks, excluding the active register.
- err_underflow  output  1  sticky; init_round arrived with the queue empty.
- err_busy  output  1  sticky; init_round arrived while round_ing was high.

Behaviour:
Reset (rstb high, asynchronous):
- msg_out=0, msg_valid=0, count=0, write/read pointers=0, both error flags=0.
- din_ready=1 once reset is released.

clr (synchronous, highest priority after reset):
- Produces the same state as reset on the next edge.
- Any push or pop in the same cycle is discarded.

Push:
- Occurs when din_valid && din_ready.
- The stored slot is din if swap_en=0.
- If swap_en=1, every lane din[64k+63:64k] is byte-reversed independently; byte 0 of the lane becomes byte 7, and lane order is unchanged.
- Write pointer increments modulo DEPTH.
- din_ready = (count != DEPTH) and is a combinational function of registered count only. A pop in the same cycle does not open space, so there is no combinational ready path from init_round.

Pop:
- Occurs when init_round && !round_ing && count != 0.
- Head slot goes to msg_out on the next edge; msg_valid=1 from then on.
- Read pointer increments modulo DEPTH.
- Latency: block visible on msg_out one cycle after the init_round edge.

Rejected init_round:
- count == 0: msg_out and msg_valid hold, err_underflow is set. There is no bypass from din to msg_out, even if a push occurs in the same cycle.
- round_ing == 1: no pop, msg_out holds, err_busy is set. If both conditions are true, both flags are set.

Simultaneous push and accepted pop:
- count unchanged; both pointers advance.
- With count=1, the popped block is the older entry, never the one being pushed.

Other rules:
- Pointer wrap-around from DEPTH-1 to 0 leaves no gap and no reorder; FIFO order is strict.
- Error flags clear only on reset or clr.
- The active register never changes while round_ing=1, regardless of push traffic.
- Reset asserted mid-operation abandons all queued blocks; no partial state survives.

Test Plan:
1. Reset, then push A=640'h0123456789ABCDEF repeated with swap_en=0, then init_round → msg_out=A two cycles after the push cycle, msg_valid=1, count=0.
2. Push lane 64'h0011223344556677 (all lanes equal) with swap_en=1, then pop → every lane of msg_out = 64'h7766554433221100.
3. Push A,B with DEPTH=2, then present C with din_valid=1 → din_ready=0 and C is not stored. Pop, then push C, then pop twice → msg_out shows A, then B, then C. This exercises pointer wrap.
4. With count=1, push B and pulse init_round in the same cycle → msg_out=A (older entry), count stays 1, and the next pop yields B.
5. Pulse init_round with count=0 → err_underflow=1 and msg_out unchanged. Then hold round_ing=1 and pulse init_round with count=1 → err_busy=1, count=1 and msg_out unchanged.
6. Assert rstb mid-stream with count=2 and msg_valid=1 → immediately count=0, msg_valid=0, msg_out=0, flags=0. After release, pulse clr with count=1 → same cleared state on the next edge.
